// File: rtl/scorer_pkg.sv
// rtl/scorer_pkg.sv - shared state encoding and widths for the tug-of-war scorer
package scorer_pkg;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        GAME_WON  = 2'd1,
        MATCH_WON = 2'd2
    } state_t;

    localparam int WINS_W = 4;

endpackage

// File: rtl/match_scorer_if.sv
// rtl/match_scorer_if.sv - round-result inputs and scoreboard outputs of match_scorer
interface match_scorer_if
    import scorer_pkg::*;
#(
    parameter int NLEDS = 7
);
    logic              winrnd;
    logic              right;
    logic              leds_on;
    logic              tie;
    logic              new_game;
    logic [NLEDS-1:0]  score;
    logic              game_over;
    logic              winner_right;
    logic              match_over;
    logic [WINS_W-1:0] wins_l;
    logic [WINS_W-1:0] wins_r;

    modport master (
        output winrnd, right, leds_on, tie, new_game,
        input  score, game_over, winner_right, match_over, wins_l, wins_r
    );

    modport slave (
        input  winrnd, right, leds_on, tie, new_game,
        output score, game_over, winner_right, match_over, wins_l, wins_r
    );
endinterface

// File: rtl/flash_timer.sv
// rtl/flash_timer.sv - divides clk into a lit/dark phase, held cleared while disabled
module flash_timer #(
    parameter int DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic phase
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CW'(DIV - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // phase 0 = winner's half lit, 1 = dark
    assign phase = phase_q;
endmodule

// File: rtl/match_scorer.sv
// rtl/match_scorer.sv - tug-of-war light position, game/match win tracking and win flash
module match_scorer
    import scorer_pkg::*;
#(
    parameter int NLEDS        = 7,
    parameter int GAMES_TO_WIN = 3,
    parameter int FLASH_DIV    = 25_000_000
) (
    input  logic           clk,
    input  logic           rst,
    match_scorer_if.slave  bus
);
    localparam int PW  = $clog2(NLEDS);
    localparam int CTR = (NLEDS - 1) / 2;
    localparam logic [PW-1:0]    CTR_P      = PW'(CTR);
    localparam logic [PW-1:0]    LEFT_END   = PW'(NLEDS - 1);
    localparam logic [NLEDS-1:0] RIGHT_HALF = {NLEDS{1'b1}} >> (NLEDS - 1 - CTR);
    localparam logic [NLEDS-1:0] LEFT_HALF  = {NLEDS{1'b1}} << CTR;

    state_t            state_q, state_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic [WINS_W-1:0] wins_l_q, wins_l_d;
    logic [WINS_W-1:0] wins_r_q, wins_r_d;
    logic              winr_q, winr_d;
    logic              phase;

    logic          event_w;
    logic          step_down;
    logic [PW-1:0] move_pos;

    flash_timer #(.DIV(FLASH_DIV)) u_flash (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q != PLAY),
        .phase (phase)
    );

    assign event_w   = (state_q == PLAY) && bus.winrnd && !bus.tie;
    // A legal right press and a left false start both pull the light toward bit 0
    assign step_down = (bus.right == bus.leds_on);
    assign move_pos  = step_down ? pos_q - 1'b1 : pos_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        wins_l_d = wins_l_q;
        wins_r_d = wins_r_q;
        winr_d   = winr_q;
        case (state_q)
            PLAY: begin
                if (event_w) begin
                    pos_d = move_pos;
                    if (move_pos == '0) begin
                        winr_d   = 1'b1;
                        wins_r_d = wins_r_q + 1'b1;
                        state_d  = (wins_r_d == WINS_W'(GAMES_TO_WIN)) ? MATCH_WON : GAME_WON;
                    end else if (move_pos == LEFT_END) begin
                        winr_d   = 1'b0;
                        wins_l_d = wins_l_q + 1'b1;
                        state_d  = (wins_l_d == WINS_W'(GAMES_TO_WIN)) ? MATCH_WON : GAME_WON;
                    end
                end
            end
            GAME_WON: begin
                if (bus.new_game) begin
                    state_d = PLAY;
                    pos_d   = CTR_P;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= PLAY;
            pos_q    <= CTR_P;
            wins_l_q <= '0;
            wins_r_q <= '0;
            winr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            wins_l_q <= wins_l_d;
            wins_r_q <= wins_r_d;
            winr_q   <= winr_d;
        end
    end

    always_comb begin
        bus.score = '0;
        if (state_q == PLAY) begin
            bus.score = NLEDS'(1) << pos_q;
        end else if (!phase) begin
            bus.score = winr_q ? RIGHT_HALF : LEFT_HALF;
        end
        bus.game_over    = (state_q != PLAY);
        bus.match_over   = (state_q == MATCH_WON);
        bus.winner_right = winr_q;
        bus.wins_l       = wins_l_q;
        bus.wins_r       = wins_r_q;
    end
endmodule

// File: tb/tb_match_scorer.sv
// tb/tb_match_scorer.sv - two scorer instances (7 and 9 LEDs) against a behavioural model
module tb_match_scorer;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic winrnd = 1'b0, right = 1'b0, leds_on = 1'b0, tie = 1'b0, new_game = 1'b0;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    match_scorer_if #(.NLEDS(7)) ifa ();
    match_scorer_if #(.NLEDS(9)) ifb ();

    assign ifa.winrnd = winrnd;   assign ifb.winrnd = winrnd;
    assign ifa.right = right;     assign ifb.right = right;
    assign ifa.leds_on = leds_on; assign ifb.leds_on = leds_on;
    assign ifa.tie = tie;         assign ifb.tie = tie;
    assign ifa.new_game = new_game; assign ifb.new_game = new_game;

    match_scorer #(.NLEDS(7), .GAMES_TO_WIN(2), .FLASH_DIV(FD)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    match_scorer #(.NLEDS(9), .GAMES_TO_WIN(3), .FLASH_DIV(FD)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    logic [8:0] d_score [2];
    logic [3:0] d_wl [2], d_wr [2];
    logic       d_go [2], d_mo [2], d_win [2];
    assign d_score[0] = 9'(ifa.score); assign d_score[1] = ifb.score;
    assign d_wl[0] = ifa.wins_l;       assign d_wl[1] = ifb.wins_l;
    assign d_wr[0] = ifa.wins_r;       assign d_wr[1] = ifb.wins_r;
    assign d_go[0] = ifa.game_over;    assign d_go[1] = ifb.game_over;
    assign d_mo[0] = ifa.match_over;   assign d_mo[1] = ifb.match_over;
    assign d_win[0] = ifa.winner_right; assign d_win[1] = ifb.winner_right;

    // Model: mst 0 = playing, 1 = game won, 2 = match won; mk = edges spent in a won state
    int nl [2] = '{7, 9};
    int gw [2] = '{2, 3};
    int mpos [2], mst [2], mwl [2], mwr [2], mk [2];
    bit mwin [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mpos[i] = (nl[i] - 1) / 2; mst[i] = 0; mwl[i] = 0; mwr[i] = 0;
                mk[i] = 0; mwin[i] = 1'b0;
            end else if (mst[i] == 0) begin
                if (winrnd && !tie) begin
                    int d;
                    d = right ? -1 : 1;
                    if (!leds_on) d = -d;
                    mpos[i] += d;
                    if (mpos[i] == 0 || mpos[i] == nl[i] - 1) begin
                        mwin[i] = (mpos[i] == 0);
                        if (mwin[i]) mwr[i]++; else mwl[i]++;
                        mk[i] = 0;
                        mst[i] = ((mwin[i] ? mwr[i] : mwl[i]) == gw[i]) ? 2 : 1;
                    end
                end
            end else begin
                mk[i]++;
                if (mst[i] == 1 && new_game) begin
                    mst[i] = 0;
                    mpos[i] = (nl[i] - 1) / 2;
                end
            end
        end
    end

    function automatic logic [8:0] exp_score(int i);
        logic [8:0] s;
        int c;
        s = '0;
        c = (nl[i] - 1) / 2;
        if (mst[i] == 0) s[mpos[i]] = 1'b1;
        else if ((mk[i] / FD) % 2 == 0)
            for (int b = 0; b < nl[i]; b++) if (mwin[i] ? (b <= c) : (b >= c)) s[b] = 1'b1;
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("m_score%0d", i), 32'(d_score[i]), 32'(exp_score(i)));
                chk($sformatf("m_game_over%0d", i), 32'(d_go[i]), 32'(mst[i] != 0));
                chk($sformatf("m_match_over%0d", i), 32'(d_mo[i]), 32'(mst[i] == 2));
                chk($sformatf("m_winner%0d", i), 32'(d_win[i]), 32'(mwin[i]));
                chk($sformatf("m_wins_l%0d", i), 32'(d_wl[i]), mwl[i]);
                chk($sformatf("m_wins_r%0d", i), 32'(d_wr[i]), mwr[i]);
            end
        end
    end

    task automatic press(input bit r, input bit l);
        winrnd = 1'b1; right = r; leds_on = l;
        @(negedge clk);
        winrnd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("reset_score_a", 32'(ifa.score), 32'(7'b0001000));
        chk("reset_score_b", 32'(ifb.score), 32'(9'b000010000));
        chk("reset_wins", {ifa.wins_l, ifa.wins_r}, 0);
        chk("reset_game_over", 32'(ifa.game_over), 0);

        press(1, 1); chk("right1", 32'(ifa.score), 32'(7'b0000100));
        press(1, 1); chk("right2", 32'(ifa.score), 32'(7'b0000010));
        press(1, 1); chk("right3", 32'(ifa.score), 32'(7'b0001111));
        chk("right_game_over", 32'(ifa.game_over), 1);
        chk("right_winner", 32'(ifa.winner_right), 1);
        chk("right_wins_r", 32'(ifa.wins_r), 1);

        press(0, 1); chk("flash_ignore_winrnd", 32'(ifa.score), 32'(7'b0001111));
        idle(2);     chk("flash_k3_lit", 32'(ifa.score), 32'(7'b0001111));
        idle(1);     chk("flash_k4_dark", 32'(ifa.score), 0);
        idle(3);     chk("flash_k7_dark", 32'(ifa.score), 0);
        idle(1);     chk("flash_k8_lit", 32'(ifa.score), 32'(7'b0001111));

        pulse_new_game();
        chk("new_game_centre", 32'(ifa.score), 32'(7'b0001000));
        chk("new_game_wins_held", 32'(ifa.wins_r), 1);

        press(0, 0); chk("false_start_left", 32'(ifa.score), 32'(7'b0000100));
        tie = 1'b1;
        press(0, 1); chk("tie_no_move", 32'(ifa.score), 32'(7'b0000100));
        tie = 1'b0;

        repeat (4) press(0, 1);
        chk("left_game1", 32'(ifa.wins_l), 1);
        chk("left_game1_not_match", 32'(ifa.match_over), 0);
        pulse_new_game();
        repeat (3) press(0, 1);
        chk("match_over", 32'(ifa.match_over), 1);
        chk("match_wins_l", 32'(ifa.wins_l), 2);
        chk("match_left_half", 32'(ifa.score), 32'(7'b1111000));
        pulse_new_game();
        chk("match_ignores_new_game", 32'(ifa.match_over), 1);
        rst = 1'b1; idle(1); rst = 1'b0;
        chk("match_reset_score", 32'(ifa.score), 32'(7'b0001000));
        chk("match_reset_flags", {ifa.match_over, ifa.game_over, ifa.wins_l, ifa.wins_r}, 0);

        press(0, 1); chk("n9_left1", 32'(ifb.score), 32'(9'b000100000));
        press(0, 1); chk("n9_left2", 32'(ifb.score), 32'(9'b001000000));
        repeat (2) press(0, 1);
        chk("n9_game_over", 32'(ifb.game_over), 1);
        idle(1);
        rst = 1'b1; idle(1); rst = 1'b0;
        chk("n9_reset_mid_flash", 32'(ifb.score), 32'(9'b000010000));
        chk("n9_reset_game_over", 32'(ifb.game_over), 0);

        for (int c = 0; c < 800; c++) begin
            rst      = ($urandom_range(0, 79) == 0);
            winrnd   = ($urandom_range(0, 2) == 0);
            right    = $urandom_range(0, 1);
            leds_on  = ($urandom_range(0, 4) != 0);
            tie      = ($urandom_range(0, 5) == 0);
            new_game = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        {rst, winrnd, tie, new_game} = '0;
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
